// File: rtl/serial_eq_cmp.sv
// serial_eq_cmp -- bit-serial unsigned word comparator.
//
// Takes two WIDTH-bit operands one bit pair per accepted cycle, MSB first,
// and reports eq/gt/lt with a one-cycle done strobe when the word completes.
// The first differing bit pair decides the result. Later pairs are still
// consumed, so the word length stays fixed, but they cannot change the result.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   reset_n   synchronous active-low reset
//   start     begin a new compare (honoured in IDLE or DONE only)
//   abort     cancel a compare in progress (RUN only), no done
//   in_valid  b1/b2 carry a valid bit pair this cycle
//   b1, b2    current bit of operand A / operand B
//   busy      high while a compare is in progress
//   done      one-cycle pulse, eq/gt/lt valid
//   eq/gt/lt  registered compare result, held until the next start/reset
module serial_eq_cmp #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  input  logic in_valid,
  input  logic b1,
  input  logic b2,
  output logic busy,
  output logic done,
  output logic eq,
  output logic gt,
  output logic lt
);

  localparam int CW = $clog2(WIDTH) + 1;
  // Count value held before the WIDTH-th pair is accepted.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   bit_cnt_q;
  logic            decided_q;
  logic            gt_acc_q;
  logic            lt_acc_q;
  logic            busy_q;
  logic            done_q;
  logic            eq_q;
  logic            gt_q;
  logic            lt_q;

  // Accumulator update for the pair on the inputs. It is only used when
  // the pair is accepted. Once decided, the bit terms are masked off.
  logic gt_bit, lt_bit, gt_d, lt_d, last_pair;

  assign gt_bit    = ~decided_q & b1 & ~b2;
  assign lt_bit    = ~decided_q & ~b1 & b2;
  assign gt_d      = gt_acc_q | gt_bit;
  assign lt_d      = lt_acc_q | lt_bit;
  assign last_pair = (bit_cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      decided_q <= 1'b0;
      gt_acc_q  <= 1'b0;
      lt_acc_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // A pair presented in the start cycle is not accepted.
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            decided_q <= 1'b0;
            gt_acc_q  <= 1'b0;
            lt_acc_q  <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
          end
        end

        RUN: begin
          // abort takes priority over a pair arriving in the same cycle.
          // Results were cleared at start, so they are left at 0.
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (in_valid) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            gt_acc_q  <= gt_d;
            lt_acc_q  <= lt_d;
            decided_q <= decided_q | gt_bit | lt_bit;
            if (last_pair) begin
              // The final pair is folded into the published result.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              gt_q    <= gt_d;
              lt_q    <= lt_d;
              eq_q    <= ~(gt_d | lt_d);
            end
          end
        end

        DONE: begin
          done_q <= 1'b0;
          // A start here allows back-to-back compares with no idle cycle.
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            decided_q <= 1'b0;
            gt_acc_q  <= 1'b0;
            lt_acc_q  <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_eq_cmp.sv
// Directed bench for serial_eq_cmp (WIDTH=8). Inputs change and outputs
// are sampled 1 ns after each rising edge. Edge T is the edge that
// samples start. The results of edge T+k appear in cycle T+k+1.
module tb_serial_eq_cmp;

  logic clk = 1'b0;
  logic reset_n, start, abort, in_valid, b1, b2;
  logic busy, done, eq, gt, lt;

  int errors = 0;
  int checks = 0;

  serial_eq_cmp #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .b1       (b1),
    .b2       (b2),
    .busy     (busy),
    .done     (done),
    .eq       (eq),
    .gt       (gt),
    .lt       (lt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic e_busy, input logic e_done,
                         input logic e_eq, input logic e_gt, input logic e_lt);
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".done"}, done, e_done);
    chk({tag, ".eq"},   eq,   e_eq);
    chk({tag, ".gt"},   gt,   e_gt);
    chk({tag, ".lt"},   lt,   e_lt);
  endtask

  // Issue start at the next edge (edge T). The pair presented here must be ignored.
  task automatic do_start(input logic jb1, input logic jb2);
    start = 1'b1; in_valid = 1'b1; b1 = jb1; b2 = jb2;
    tick();
    start = 1'b0; in_valid = 1'b0;
  endtask

  // Present pairs from bit index hi down to bit index lo, one per edge, with no bubbles.
  task automatic send_bits(input logic [7:0] a, input logic [7:0] b,
                           input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      b1 = a[i]; b2 = b[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; b1 = 1'b0; b2 = 1'b0;
    tick(); tick();
    chk_res("reset", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();
    chk_res("idle", 0, 0, 0, 0, 0);

    // Equal operands 0xA5/0xA5. done follows the 8th accepted pair.
    do_start(1'b0, 1'b1);
    chk_res("eq.T1", 1, 0, 0, 0, 0);
    send_bits(8'hA5, 8'hA5, 7, 1);
    chk("eq.pre_done", done, 1'b0);
    send_bits(8'hA5, 8'hA5, 0, 0);
    chk_res("eq.done", 0, 1, 1, 0, 0);
    repeat (11) tick();
    chk_res("eq.hold", 0, 0, 1, 0, 0);

    // MSB decides 0x80 > 0x7F. The result is not visible before done.
    do_start(1'b0, 1'b1);
    chk("msb.eq_cleared", eq, 1'b0);
    send_bits(8'h80, 8'h7F, 7, 7);
    chk("msb.gt_not_early", gt, 1'b0);
    send_bits(8'h80, 8'h7F, 6, 0);
    chk_res("msb.done", 0, 1, 0, 1, 0);
    tick();
    chk_res("msb.after", 0, 0, 0, 1, 0);

    // LSB decides.
    do_start(1'b1, 1'b0);
    send_bits(8'h10, 8'h11, 7, 0);
    chk_res("lsb.lt", 0, 1, 0, 0, 1);
    tick();
    do_start(1'b0, 1'b1);
    send_bits(8'hFF, 8'hFE, 7, 0);
    chk_res("lsb.gt", 0, 1, 0, 1, 0);
    tick();

    // Bubbles. 0x3C/0x3C with three idle cycles. start pulses during RUN must be ignored.
    do_start(1'b0, 1'b0);
    send_bits(8'h3C, 8'h3C, 7, 6);
    start = 1'b1; tick(); start = 1'b0;               // bubble 1 with start
    send_bits(8'h3C, 8'h3C, 5, 4);
    tick();                                           // bubble 2
    b1 = 1'b1; b2 = 1'b1; start = 1'b1;               // start with a valid pair
    send_bits(8'h3C, 8'h3C, 3, 3);
    start = 1'b0;
    send_bits(8'h3C, 8'h3C, 2, 1);
    tick();                                           // bubble 3
    chk_res("bub.pre_done", 1, 0, 0, 0, 0);
    send_bits(8'h3C, 8'h3C, 0, 0);
    chk_res("bub.done", 0, 1, 1, 0, 0);
    tick();
    chk_res("bub.no_extra", 0, 0, 1, 0, 0);

    // Abort after 4 bits, in the same cycle as a valid pair.
    do_start(1'b0, 1'b0);
    send_bits(8'h80, 8'h00, 7, 4);
    abort = 1'b1; in_valid = 1'b1; b1 = 1'b1; b2 = 1'b0;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk_res("abort", 0, 0, 0, 0, 0);
    send_bits(8'hFF, 8'h00, 7, 0);                    // ignored in IDLE
    chk_res("abort.idle", 0, 0, 0, 0, 0);

    // Reset after 5 bits.
    do_start(1'b0, 1'b0);
    send_bits(8'h00, 8'hFF, 7, 3);
    reset_n = 1'b0; start = 1'b1; in_valid = 1'b1;
    tick();
    reset_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    chk_res("rst_mid", 0, 0, 0, 0, 0);
    send_bits(8'h00, 8'hFF, 2, 0);                    // ignored in IDLE
    chk_res("rst_idle", 0, 0, 0, 0, 0);
    do_start(1'b1, 1'b0);
    send_bits(8'h01, 8'h02, 7, 0);
    chk_res("post_rst.lt", 0, 1, 0, 0, 1);
    tick();

    // Back-to-back. A start in the DONE cycle goes straight to RUN.
    do_start(1'b0, 1'b0);
    send_bits(8'h55, 8'h55, 7, 0);
    chk_res("b2b.first", 0, 1, 1, 0, 0);
    abort = 1'b1;                                     // no effect in DONE
    do_start(1'b1, 1'b0);                             // edge T2
    abort = 1'b0;
    chk_res("b2b.restart", 1, 0, 0, 0, 0);
    send_bits(8'h00, 8'h01, 7, 1);
    chk("b2b.pre_done", done, 1'b0);
    send_bits(8'h00, 8'h01, 0, 0);
    chk_res("b2b.second", 0, 1, 0, 0, 1);
    tick();
    chk_res("b2b.hold", 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
